// File: rtl/pipe_pkg.sv
// Shared types and sizing helpers for the elastic pipeline register chain.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } skid_state_t;

  // Occupancy ranges over 0..2*depth inclusive, hence the +1.
  function automatic int occ_w(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/skid_stage.sv
// One skid-buffered slot: the main register drives downstream, and the skid register
// catches the single word that arrives while downstream is stalled.
module skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              flush_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [DATA_W-1:0] dn_data_o
);

  skid_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              live;
  logic              accept;
  logic              take;

  assign live   = en_i & ~flush_i;
  assign accept = up_valid_i & up_ready_o;
  assign take   = dn_valid_o & dn_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // With en low, accept and take are both forced low, so everything holds.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (en_i && flush_i) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = BUSY;
            main_d  = up_data_i;
          end
        end
        BUSY: begin
          if (accept && take) begin
            main_d = up_data_i;
          end else if (accept) begin
            state_d = FULL;
            skid_d  = up_data_i;
          end else if (take) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (take) begin
            state_d = BUSY;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // Ready depends only on this stage's own registered state, never on dn_ready_i.
  always_comb begin
    up_ready_o = live && ((state_q == EMPTY) || (state_q == BUSY));
    dn_valid_o = live && ((state_q == BUSY) || (state_q == FULL));
    dn_data_o  = main_q;
  end

  a_skid_clear_unless_full: assert property (
    @(posedge clk_i) disable iff (!rst_ni) (state_q != FULL) |-> (skid_q == '0));

  a_state_legal: assert property (
    @(posedge clk_i) disable iff (!rst_ni) state_q inside {EMPTY, BUSY, FULL});

endmodule

// File: rtl/pipe_stage_elastic.sv
// DEPTH-deep chain of skid stages with a valid/ready handshake, global enable,
// synchronous flush and a registered count of words held in the chain.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [DATA_W-1:0]        in_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DATA_W-1:0]        out_data_o,
  output logic [occ_w(DEPTH)-1:0]  occupancy_o
);

  localparam int              OccW   = occ_w(DEPTH);
  localparam logic [OccW-1:0] OccMax = OccW'(2 * DEPTH);

  logic [DEPTH:0]    chainValid;
  logic [DEPTH:0]    chainReady;
  logic [DATA_W-1:0] chainData [DEPTH+1];

  logic              inXfer;
  logic              outXfer;
  logic [OccW-1:0]   occupancy_q, occupancy_d;

  assign chainValid[0]     = in_valid_i;
  assign chainData[0]      = in_data_i;
  assign chainReady[DEPTH] = out_ready_i;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    skid_stage #(
      .DATA_W(DATA_W)
    ) u_stage (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .en_i       (en_i),
      .flush_i    (flush_i),
      .up_valid_i (chainValid[i]),
      .up_ready_o (chainReady[i]),
      .up_data_i  (chainData[i]),
      .dn_valid_o (chainValid[i+1]),
      .dn_ready_i (chainReady[i+1]),
      .dn_data_o  (chainData[i+1])
    );
  end

  // The stages come out of reset EMPTY, so ready is masked externally while reset is held.
  assign in_ready_o  = rst_ni & chainReady[0];
  assign out_valid_o = chainValid[DEPTH];
  assign out_data_o  = chainData[DEPTH];

  assign inXfer  = in_valid_i & chainReady[0];
  assign outXfer = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occupancy_q <= '0;
    end else begin
      occupancy_q <= occupancy_d;
    end
  end

  always_comb begin
    occupancy_d = occupancy_q;
    if (en_i && flush_i) begin
      occupancy_d = '0;
    end else if (inXfer && !outXfer) begin
      occupancy_d = occupancy_q + OccW'(1);
    end else if (outXfer && !inXfer) begin
      occupancy_d = occupancy_q - OccW'(1);
    end
  end

  assign occupancy_o = occupancy_q;

  a_occ_bounded: assert property (
    @(posedge clk_i) disable iff (!rst_ni) occupancy_q <= OccMax);

  a_no_accept_when_full: assert property (
    @(posedge clk_i) disable iff (!rst_ni) inXfer |-> (occupancy_q < OccMax));

  a_no_deliver_when_empty: assert property (
    @(posedge clk_i) disable iff (!rst_ni) outXfer |-> (occupancy_q != '0));

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench: directed scenarios on a DEPTH=2 chain and a random soak on a
// DEPTH=3 chain against a queue model of the words that should be in flight.
module tb_pipe_stage_elastic;
  import pipe_pkg::*;

  localparam int DataW = 32;
  localparam int OccW2 = occ_w(2);
  localparam int OccW3 = occ_w(3);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN;

  logic             en2, flush2, inValid2, inReady2, outValid2, outReady2;
  logic [DataW-1:0] inData2, outData2;
  logic [OccW2-1:0] occ2;

  logic             en3, flush3, inValid3, inReady3, outValid3, outReady3;
  logic [DataW-1:0] inData3, outData3;
  logic [OccW3-1:0] occ3;

  int checks = 0;
  int errors = 0;

  logic [DataW-1:0] model [$];

  pipe_stage_elastic #(.DATA_W(DataW), .DEPTH(2)) dut2 (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .en_i        (en2),
    .flush_i     (flush2),
    .in_valid_i  (inValid2),
    .in_ready_o  (inReady2),
    .in_data_i   (inData2),
    .out_valid_o (outValid2),
    .out_ready_i (outReady2),
    .out_data_o  (outData2),
    .occupancy_o (occ2)
  );

  pipe_stage_elastic #(.DATA_W(DataW), .DEPTH(3)) dut3 (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .en_i        (en3),
    .flush_i     (flush3),
    .in_valid_i  (inValid3),
    .in_ready_o  (inReady3),
    .in_data_i   (inData3),
    .out_valid_o (outValid3),
    .out_ready_i (outReady3),
    .out_data_o  (outData3),
    .occupancy_o (occ3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    en2 = 1'b1; flush2 = 1'b0; inValid2 = 1'b1; inData2 = 32'hAA; outReady2 = 1'b0;
    en3 = 1'b1; flush3 = 1'b0; inValid3 = 1'b1; inData3 = 32'hBB; outReady3 = 1'b0;
    repeat (3) step();
    checks++; if (inReady2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", inReady2); end
    checks++; if (outValid2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", outValid2); end
    checks++; if (outData2 !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 0", outData2); end
    checks++; if (occ2 !== '0) begin errors++; $display("[TB] FAIL reset_occupancy: got %0d expected 0", occ2); end
    checks++; if (inReady3 !== 1'b0 || occ3 !== '0) begin errors++; $display("[TB] FAIL reset_depth3: in_ready %b occ %0d expected 0 0", inReady3, occ3); end
    inValid2 = 1'b0;
    inValid3 = 1'b0;
    rstN = 1'b1;
    step();
    checks++; if (inReady2 !== 1'b1) begin errors++; $display("[TB] FAIL release_in_ready: got %b expected 1", inReady2); end
    checks++; if (occ2 !== '0 || outValid2 !== 1'b0) begin errors++; $display("[TB] FAIL release_idle: occ %0d out_valid %b expected 0 0", occ2, outValid2); end
  endtask

  task automatic test_latency();
    outReady2 = 1'b1;
    inValid2 = 1'b1; inData2 = 32'd5;
    step();
    inData2 = 32'd30;
    #1;
    checks++; if (outValid2 !== 1'b0) begin errors++; $display("[TB] FAIL lat_not_early: out_valid %b expected 0", outValid2); end
    step();
    inValid2 = 1'b0;
    #1;
    checks++; if (outValid2 !== 1'b1 || outData2 !== 32'd5) begin errors++; $display("[TB] FAIL lat_first: valid %b data %0d expected 1 5", outValid2, outData2); end
    checks++; if (occ2 !== 3'd2) begin errors++; $display("[TB] FAIL lat_occ2: got %0d expected 2", occ2); end
    step();
    checks++; if (outValid2 !== 1'b1 || outData2 !== 32'd30) begin errors++; $display("[TB] FAIL lat_second: valid %b data %0d expected 1 30", outValid2, outData2); end
    checks++; if (occ2 !== 3'd1) begin errors++; $display("[TB] FAIL lat_occ1: got %0d expected 1", occ2); end
    step();
    checks++; if (occ2 !== 3'd0 || outValid2 !== 1'b0) begin errors++; $display("[TB] FAIL lat_drained: occ %0d valid %b expected 0 0", occ2, outValid2); end
  endtask

  task automatic test_back_pressure();
    outReady2 = 1'b0;
    inValid2 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      inData2 = DataW'(k);
      #1;
      checks++; if (inReady2 !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_word%0d: got %b expected 1", k, inReady2); end
      step();
    end
    inData2 = 32'd5;
    #1;
    checks++; if (inReady2 !== 1'b0) begin errors++; $display("[TB] FAIL bp_full_ready: got %b expected 0", inReady2); end
    checks++; if (occ2 !== 3'd4) begin errors++; $display("[TB] FAIL bp_full_occ: got %0d expected 4", occ2); end
    step();
    checks++; if (occ2 !== 3'd4) begin errors++; $display("[TB] FAIL bp_word5_rejected: occ %0d expected 4", occ2); end
    inValid2 = 1'b0;
    outReady2 = 1'b1;
    #1;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (outValid2 !== 1'b1 || outData2 !== DataW'(k)) begin
        errors++; $display("[TB] FAIL bp_drain%0d: valid %b data %0d expected 1 %0d", k, outValid2, outData2, k);
      end
      step();
    end
    checks++; if (occ2 !== 3'd0 || outValid2 !== 1'b0) begin errors++; $display("[TB] FAIL bp_empty: occ %0d valid %b expected 0 0", occ2, outValid2); end
  endtask

  task automatic test_enable();
    outReady2 = 1'b0;
    inValid2 = 1'b1; inData2 = 32'd11;
    step();
    inData2 = 32'd22;
    step();
    en2 = 1'b0; inValid2 = 1'b1; inData2 = 32'd99; outReady2 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (outValid2 !== 1'b0 || inReady2 !== 1'b0 || occ2 !== 3'd2) begin
        errors++; $display("[TB] FAIL en_off_cycle%0d: valid %b ready %b occ %0d expected 0 0 2", c, outValid2, inReady2, occ2);
      end
      step();
    end
    en2 = 1'b1; inValid2 = 1'b0;
    #1;
    checks++; if (outValid2 !== 1'b1 || outData2 !== 32'd11) begin errors++; $display("[TB] FAIL en_resume1: valid %b data %0d expected 1 11", outValid2, outData2); end
    step();
    checks++; if (outValid2 !== 1'b1 || outData2 !== 32'd22) begin errors++; $display("[TB] FAIL en_resume2: valid %b data %0d expected 1 22", outValid2, outData2); end
    step();
    checks++; if (occ2 !== 3'd0) begin errors++; $display("[TB] FAIL en_drained: occ %0d expected 0", occ2); end
  endtask

  task automatic test_flush();
    outReady2 = 1'b0; inValid2 = 1'b1;
    for (int k = 7; k <= 9; k++) begin
      inData2 = DataW'(k);
      step();
    end
    inValid2 = 1'b0;
    #1;
    checks++; if (occ2 !== 3'd3) begin errors++; $display("[TB] FAIL flush_pre_occ: got %0d expected 3", occ2); end
    flush2 = 1'b1; inValid2 = 1'b1; inData2 = 32'd55; outReady2 = 1'b1;
    #1;
    checks++; if (inReady2 !== 1'b0 || outValid2 !== 1'b0) begin errors++; $display("[TB] FAIL flush_gating: ready %b valid %b expected 0 0", inReady2, outValid2); end
    step();
    flush2 = 1'b0; inValid2 = 1'b0;
    #1;
    checks++;
    if (occ2 !== 3'd0 || outValid2 !== 1'b0 || outData2 !== 32'h0) begin
      errors++; $display("[TB] FAIL flush_after: occ %0d valid %b data %h expected 0 0 0", occ2, outValid2, outData2);
    end
  endtask

  // Random traffic; the model is just the ordered list of words accepted and not yet delivered.
  task automatic test_random_soak();
    logic inX, outX;
    int   budget;
    model.delete();
    en3 = 1'b1; flush3 = 1'b0; inValid3 = 1'b0; outReady3 = 1'b0;
    step();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      en3       = ($urandom_range(0, 9) != 0);
      flush3    = ($urandom_range(0, 199) == 0);
      inValid3  = ($urandom_range(0, 3) != 0);
      outReady3 = ($urandom_range(0, 1) != 0);
      inData3   = $urandom();
      #1;
      checks++; if (occ3 !== OccW3'(model.size())) begin errors++; $display("[TB] FAIL soak_occ cyc %0d: got %0d expected %0d", cyc, occ3, model.size()); end
      if (!en3 || flush3) begin
        checks++; if (inReady3 !== 1'b0 || outValid3 !== 1'b0) begin errors++; $display("[TB] FAIL soak_gated cyc %0d: ready %b valid %b expected 0 0", cyc, inReady3, outValid3); end
      end else if (model.size() == 0) begin
        checks++; if (inReady3 !== 1'b1) begin errors++; $display("[TB] FAIL soak_empty_ready cyc %0d: got %b expected 1", cyc, inReady3); end
      end
      if (model.size() == 6) begin
        checks++; if (inReady3 !== 1'b0) begin errors++; $display("[TB] FAIL soak_full_ready cyc %0d: got %b expected 0", cyc, inReady3); end
      end
      if (outValid3 === 1'b1) begin
        checks++;
        if (model.size() == 0) begin
          errors++; $display("[TB] FAIL soak_spurious cyc %0d: out_valid 1 with %0d words expected", cyc, model.size());
        end else if (outData3 !== model[0]) begin
          errors++; $display("[TB] FAIL soak_order cyc %0d: got %h expected %h", cyc, outData3, model[0]);
        end
      end
      inX  = inValid3 & inReady3;
      outX = outValid3 & outReady3;
      @(posedge clk);
      if (en3 && flush3) begin
        model.delete();
      end else begin
        if (outX && model.size() > 0) void'(model.pop_front());
        if (inX) model.push_back(inData3);
      end
      #1;
    end
    en3 = 1'b1; flush3 = 1'b0; inValid3 = 1'b0; outReady3 = 1'b1;
    budget = 0;
    while (model.size() > 0 && budget < 40) begin
      #1;
      checks++;
      if (outValid3 === 1'b1 && outData3 !== model[0]) begin
        errors++; $display("[TB] FAIL soak_drain_order: got %h expected %h", outData3, model[0]);
      end
      outX = outValid3;
      step();
      if (outX) void'(model.pop_front());
      budget++;
    end
    checks++; if (model.size() != 0) begin errors++; $display("[TB] FAIL soak_drain_timeout: %0d words left expected 0", model.size()); end
    checks++; if (occ3 !== '0) begin errors++; $display("[TB] FAIL soak_final_occ: got %0d expected 0", occ3); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_pressure();
    test_enable();
    test_flush();
    test_random_soak();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised successor to the fixed inter-stage pipeline registers (IF/ID … MEM/WB). It is a DEPTH-deep chain of skid-buffered registers carrying a packed DATA_W payload, with a valid/ready handshake, a global stall enable and a synchronous flush. The CPU pipeline uses it wherever a stage must absorb back-pressure without a combinational ready path, for example before the memory unit or the writeback arbiter.

Parameters:
DATA_W, 32, payload width in bits; caller packs rd/rt/ALU result/control fields.
DEPTH, 1, number of chained skid stages (>=1); sets forward latency.

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-low reset.
en  in  1  global enable. 0 freezes all state and blocks both handshakes.
flush  in  1  synchronous bubble insertion. Empties every stage.
in_valid  in  1  producer has data.
in_ready  out  1  block accepts data this cycle.
in_data  in  DATA_W  payload in.
out_valid  out  1  head entry valid.
out_ready  in  1  consumer accepts this cycle.
out_data  out  DATA_W  head payload.
occupancy  out  $clog2(2*DEPTH+1)  total valid entries across all stages.

Behaviour:
- Reset (reset=0, async): every stage goes to EMPTY and all main/skid registers clear to 0. in_ready=0, out_valid=0, out_data=0, occupancy=0 while reset is held. After release: in_ready=en & ~flush.
- Transfers: input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready. Both are sampled at the rising clk edge.
- Gating: in_ready = en & ~flush & (stage0 != FULL). out_valid = en & ~flush & (last stage != EMPTY). out_data = last stage main register, shown even when out_valid=0.
- Stage FSM, one per stage. States: EMPTY (no entries), BUSY (main valid), FULL (main + skid valid).
  - EMPTY: upstream ready=1, downstream valid=0. Accept -> BUSY, data to main.
  - BUSY: upstream ready=1, downstream valid=1.
    - accept & take -> BUSY, main replaced.
    - accept only -> FULL, data to skid.
    - take only -> EMPTY.
  - FULL: upstream ready=0, downstream valid=1. take -> BUSY, skid moves to main, skid clears to 0.
  - Each stage's upstream ready is a registered function of its own state, so there is no combinational ready chain across stages.
- Latency: an empty chain with out_ready=1 presents an accepted word on out_data/out_valid DEPTH cycles after its input edge. Throughput is 1 word/cycle sustained.
- Capacity: 2*DEPTH words. With out_ready=0, in_ready drops after 2*DEPTH accepts.
- Ordering: strict FIFO. No word is lost or duplicated under any ready/valid pattern.
- en=0: all registers and states hold, no transfers occur, and occupancy holds.
- flush=1 with en=1: on the next edge all stages go to EMPTY, data clears to 0 and occupancy=0. Flush has priority over simultaneous input and output handshakes; both are suppressed by the gating above, so nothing is accepted or delivered in the flush cycle.
- flush=1 with en=0: ignored, state holds.
- Occupancy: +1 on input transfer, -1 on output transfer, unchanged when both occur. It is registered and equals the sum of valid main+skid bits. It never exceeds 2*DEPTH and never underflows.
- Reset asserted mid-operation: immediate async clear as above. In-flight data is discarded.

Decomposition:
- Shared package pipe_pkg:
  - typedef enum logic [1:0] skid_state_t {EMPTY=2'b00, BUSY=2'b01, FULL=2'b10}.
  - function occ_w(depth) returning $clog2(2*depth+1).
- Sub-module skid_stage (DATA_W param):
  - contains one FSM plus main/skid registers, with ports clk, reset, en, flush, up_valid/up_ready/up_data, dn_valid/dn_ready/dn_data.
  - pipe_stage_elastic instantiates DEPTH copies via generate and keeps the occupancy counter.

Test Plan:
- Reset, DEPTH=2, DATA_W=32: hold reset=0 with in_valid=1, in_data=32'hAA -> in_ready=0, out_valid=0, out_data=0, occupancy=0. Release -> in_ready=1 next cycle.
- Latency: DEPTH=2, out_ready=1, push 32'd5 then 32'd30 on consecutive cycles -> out_data=5 with out_valid=1 two edges after the first accept, 30 one cycle later, occupancy returns to 0.
- Back-pressure: DEPTH=2, out_ready=0, push 1,2,3,4,5 -> in_ready=0 after the 4th accept, occupancy=4, word 5 not accepted. Raise out_ready -> out sequence 1,2,3,4 in order.
- Enable off: 2 entries held, en=0 for 3 cycles with in_valid=1, out_ready=1 -> out_valid=0, in_ready=0, occupancy stays 2. en=1 -> original 2 words emerge unchanged.
- Flush: occupancy=3, assert flush=1 for one cycle with in_valid=1, out_ready=1 -> no transfer that cycle, occupancy=0 and out_valid=0 next cycle, out_data=0.
- Random soak: DEPTH=3, 10k cycles of random in_valid/out_ready/en, rare flush -> scoreboard shows in-order delivery, no loss except flushed words, and occupancy always matches the model (<=6).
